// File: rtl/matrix_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// matrix_scan_ctrl_if : request/enable in, line valid/code/ack/busy out.
// Revision: 1.0
// ============================================================================
interface matrix_scan_ctrl_if;
   logic       en;
   logic [6:0] req;
   logic       V;
   logic       Ch2;
   logic       Ch1;
   logic       Ch0;
   logic [6:0] ack;
   logic       busy;

   modport master (
      output en, req,
      input  V, Ch2, Ch1, Ch0, ack, busy
   );

   modport slave (
      input  en, req,
      output V, Ch2, Ch1, Ch0, ack, busy
   );
endinterface
`default_nettype wire

// File: rtl/matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// matrix_scan_ctrl : round-robin 7-line matrix scanner with blank/dwell timing.
// Revision: 1.0
// ============================================================================
module matrix_scan_ctrl #(
   parameter int DWELL = 4,
   parameter int BLANK = 1
) (
   input  logic               clk,
   input  logic               rst,
   matrix_scan_ctrl_if.slave  bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BLANK = 2'd1;
   localparam logic [1:0] S_SHOW  = 2'd2;

   localparam logic [7:0] C_BLANK_LD  = 8'(BLANK - 1);
   localparam logic [7:0] C_DWELL_LD  = 8'(DWELL - 1);
   localparam logic       C_DWELL_ONE = (DWELL == 1);

   logic [1:0] r_state;
   logic [7:0] r_cnt;
   logic [2:0] r_grant;
   logic [2:0] r_last;
   logic       r_v;
   logic [2:0] r_code;
   logic [6:0] r_ack;
   logic       r_busy;

   logic [2:0] w_base;
   logic [2:0] w_pick;
   logic       w_start;
   logic [6:0] w_onehot;

   // First set request scanning upward from base+1, wrapping 6 -> 0.
   function automatic logic [2:0] rr_pick(input logic [6:0] r, input logic [2:0] b);
      logic [2:0] p;
      logic [3:0] s;
      p = 3'd0;
      for (int i = 7; i >= 1; i--) begin
         s = {1'b0, b} + 4'(i);
         if (s >= 4'd7) s = s - 4'd7;
         if (r[s[2:0]]) p = s[2:0];
      end
      return p;
   endfunction

   // At the end of SHOW the line being finished becomes the new base.
   assign w_base   = (r_state == S_SHOW) ? r_grant : r_last;
   assign w_pick   = rr_pick(bus.req, w_base);
   assign w_start  = bus.en && (bus.req != 7'd0);
   assign w_onehot = 7'b1 << r_grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_grant <= 3'd0;
         r_last  <= 3'd6;
         r_v     <= 1'b0;
         r_code  <= 3'd0;
         r_ack   <= 7'd0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_v    <= 1'b0;
               r_code <= 3'd0;
               r_ack  <= 7'd0;
               if (w_start) begin
                  r_grant <= w_pick;
                  r_cnt   <= C_BLANK_LD;
                  r_state <= S_BLANK;
                  r_busy  <= 1'b1;
               end else begin
                  r_busy  <= 1'b0;
               end
            end
            S_BLANK: begin
               r_busy <= 1'b1;
               if (r_cnt == 8'd0) begin
                  r_state <= S_SHOW;
                  r_cnt   <= C_DWELL_LD;
                  r_v     <= 1'b1;
                  r_code  <= r_grant + 3'd1;
                  r_ack   <= C_DWELL_ONE ? w_onehot : 7'd0;
               end else begin
                  r_cnt   <= r_cnt - 8'd1;
                  r_v     <= 1'b0;
                  r_code  <= 3'd0;
                  r_ack   <= 7'd0;
               end
            end
            S_SHOW: begin
               if (r_cnt == 8'd0) begin
                  r_last <= r_grant;
                  r_v    <= 1'b0;
                  r_code <= 3'd0;
                  r_ack  <= 7'd0;
                  if (w_start) begin
                     r_grant <= w_pick;
                     r_cnt   <= C_BLANK_LD;
                     r_state <= S_BLANK;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt  <= r_cnt - 8'd1;
                  r_busy <= 1'b1;
                  // Pulse lands in the final dwell cycle.
                  r_ack  <= (r_cnt == 8'd1) ? w_onehot : 7'd0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_v     <= 1'b0;
               r_code  <= 3'd0;
               r_ack   <= 7'd0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.V    = r_v;
   assign bus.Ch2  = r_code[2];
   assign bus.Ch1  = r_code[1];
   assign bus.Ch0  = r_code[0];
   assign bus.ack  = r_ack;
   assign bus.busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_matrix_scan_ctrl : table vectors, corner sequences and random run vs model.
// Revision: 1.0
// ============================================================================
module tb_matrix_scan_ctrl;

   localparam int DW = 4;
   localparam int BL = 1;

   logic clk;
   logic rst;

   matrix_scan_ctrl_if bus ();

   matrix_scan_ctrl #(.DWELL(DW), .BLANK(BL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       en;
      logic [6:0] req;
      logic       v;
      logic [2:0] code;
      logic [6:0] ack;
      logic       busy;
   } vec_t;

   vec_t tbl [10];

   int total;
   int bad;

   // Reference: a grant is one block of BLANK+DWELL cycles; the last DWELL are lit.
   int m_active;
   int m_left;
   int m_grant;
   int m_last;
   int grant_log[$];

   function automatic int rr(input logic [6:0] r, input int base);
      for (int i = 1; i <= 7; i++) begin
         int j;
         j = (base + i) % 7;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_active = 0;
      m_left   = 0;
      m_grant  = 0;
      m_last   = 6;
   endtask

   task automatic model_edge(input logic en, input logic [6:0] req);
      if (m_active == 0) begin
         if (en && req != 7'd0) begin
            m_grant  = rr(req, m_last);
            m_left   = BL + DW;
            m_active = 1;
         end
      end else begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_last = m_grant;
            if (en && req != 7'd0) begin
               m_grant = rr(req, m_last);
               m_left  = BL + DW;
            end else begin
               m_active = 0;
            end
         end
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] dut_code();
      return {bus.Ch2, bus.Ch1, bus.Ch0};
   endfunction

   task automatic check_model();
      int lit;
      lit = (m_active != 0) && (m_left <= DW);
      check("v",    int'(bus.V),      lit);
      check("code", int'(dut_code()), lit ? m_grant + 1 : 0);
      check("ack",  int'(bus.ack),    (lit && m_left == 1) ? (1 << m_grant) : 0);
      check("busy", int'(bus.busy),   m_active);
   endtask

   // One clock: drive inputs, advance model at the edge, compare just after it.
   task automatic step(input logic en, input logic [6:0] req);
      bus.en  = en;
      bus.req = req;
      @(posedge clk);
      model_edge(en, req);
      #1;
      check_model();
      for (int k = 0; k < 7; k++)
         if (bus.ack[k]) grant_log.push_back(k);
   endtask

   task automatic do_reset();
      bus.en  = 1'b0;
      bus.req = 7'd0;
      rst     = 1'b1;
      #1;
      model_reset();
      check("rst_v",    int'(bus.V),      0);
      check("rst_code", int'(dut_code()), 0);
      check("rst_ack",  int'(bus.ack),    0);
      check("rst_busy", int'(bus.busy),   0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      grant_log.delete();
   endtask

   task automatic check_log(input string name, input int exp[$]);
      check({name, "_count"}, grant_log.size(), exp.size());
      for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
         check(name, grant_log[i], exp[i]);
   endtask

   initial begin
      int q[$];
      int n;
      total   = 0;
      bad     = 0;
      rst     = 1'b0;
      bus.en  = 1'b0;
      bus.req = 7'd0;
      model_reset();

      // Single requester L2: blank, four lit cycles, ack on the last, repeat.
      tbl[0] = '{1'b1, 7'b0000100, 1'b0, 3'd0, 7'd0,        1'b1};
      tbl[1] = '{1'b1, 7'b0000100, 1'b1, 3'd3, 7'd0,        1'b1};
      tbl[2] = '{1'b1, 7'b0000100, 1'b1, 3'd3, 7'd0,        1'b1};
      tbl[3] = '{1'b1, 7'b0000100, 1'b1, 3'd3, 7'd0,        1'b1};
      tbl[4] = '{1'b1, 7'b0000100, 1'b1, 3'd3, 7'b0000100,  1'b1};
      tbl[5] = '{1'b1, 7'b0000100, 1'b0, 3'd0, 7'd0,        1'b1};
      tbl[6] = '{1'b1, 7'b0000100, 1'b1, 3'd3, 7'd0,        1'b1};
      tbl[7] = '{1'b1, 7'b0000100, 1'b1, 3'd3, 7'd0,        1'b1};
      tbl[8] = '{1'b1, 7'b0000100, 1'b1, 3'd3, 7'd0,        1'b1};
      tbl[9] = '{1'b1, 7'b0000100, 1'b1, 3'd3, 7'b0000100,  1'b1};

      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].en, tbl[i].req);
         check("tbl_v",    int'(bus.V),      int'(tbl[i].v));
         check("tbl_code", int'(dut_code()), int'(tbl[i].code));
         check("tbl_ack",  int'(bus.ack),    int'(tbl[i].ack));
         check("tbl_busy", int'(bus.busy),   int'(tbl[i].busy));
      end

      // L0 and L6 alternate.
      do_reset();
      for (int i = 0; i < 4 * (BL + DW); i++) step(1'b1, 7'b1000001);
      q = '{0, 6, 0, 6};
      check_log("alt", q);

      // All requesting: L0..L6 then wrap to L0.
      do_reset();
      for (int i = 0; i < 8 * (BL + DW); i++) step(1'b1, 7'h7F);
      q = '{0, 1, 2, 3, 4, 5, 6, 0};
      check_log("wrap", q);

      // Drop req and en in the 2nd lit cycle: dwell still completes, then idle.
      do_reset();
      n = 0;
      while (!bus.V && n < 10) begin
         step(1'b1, 7'b0000100);
         n++;
      end
      check("v_rise_timeout", int'(bus.V), 1);
      step(1'b1, 7'b0000100);
      for (int i = 0; i < 4; i++) step(1'b0, 7'd0);
      q = '{2};
      check_log("drop", q);
      check("drop_idle_busy", int'(bus.busy), 0);

      // Async reset in the 3rd lit cycle of L2, then lowest request wins.
      do_reset();
      n = 0;
      while (!bus.V && n < 10) begin
         step(1'b1, 7'b0000100);
         n++;
      end
      check("v_rise_timeout2", int'(bus.V), 1);
      step(1'b1, 7'b0000100);
      step(1'b1, 7'b0000100);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("arst_v",    int'(bus.V),      0);
      check("arst_code", int'(dut_code()), 0);
      check("arst_ack",  int'(bus.ack),    0);
      check("arst_busy", int'(bus.busy),   0);
      #1;
      rst = 1'b0;
      grant_log.delete();
      for (int i = 0; i < BL + DW; i++) step(1'b1, 7'b0110000);
      q = '{4};
      check_log("after_rst", q);

      // Random traffic against the model, with occasional async resets.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic       e;
         logic [6:0] r;
         e = ($urandom_range(0, 7) != 0);
         r = 7'($urandom);
         if ($urandom_range(0, 3) == 0) r = 7'd0;
         step(e, r);
         if ($urandom_range(0, 60) == 0) begin
            #2;
            rst = 1'b1;
            #1;
            model_reset();
            check_model();
            #1;
            rst = 1'b0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
